apb_master: RTL and testbench

Single-outstanding APB requester that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers. It drives the APB slave register bank (n0..n6, addresses 0-6) and returns read data and error/timeout status on a valid/ready response interface. It sits between the CPU-side command source and the APB bus, one transfer in flight at a time.

---
 rtl/apb_master_if.sv | 45 ++++
 rtl/apb_master.sv | 136 +++++++++++++
 tb/tb_apb_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_master_if : command, response and APB bus bundle for apb_master
// Revision 1.0
// ---------------------------------------------------------------------------
interface apb_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_master : single-outstanding valid/ready to APB requester with timeout
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  apb_master_if.master    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]        state_q,   state_d;
  logic              psel_q,    psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              tmo_q,     tmo_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  // Fires on the ACCESS cycle whose stall would make the wait count reach TIMEOUT.
  logic tmo_hit;
  assign tmo_hit = TMO_EN && !bus.PREADY && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (bus.PREADY || tmo_hit) state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          cnt_d    = '0;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          // Read data is only meaningful for a successful read.
          rdata_d   = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
          err_d     = bus.PSLVERR;
          tmo_d     = 1'b0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (tmo_hit) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            rdata_d   = '0;
            err_d     = 1'b1;
            tmo_d     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_master : random transactions against a transaction-level trace model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_apb_master;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: register bank n0..n6 (n1 is 16 bits), addr 7 errors; wait_n stall cycles per access
  logic [31:0] bank [0:7];
  int          acc_cnt = 0;
  int          wait_n  = 0;
  logic        junk_rdy, junk_err;
  logic [31:0] junk_data;
  logic        completing;

  assign completing  = bus.PSEL && bus.PENABLE && (acc_cnt >= wait_n);
  assign bus.PREADY  = (bus.PSEL && bus.PENABLE) ? completing : junk_rdy;
  assign bus.PRDATA  = completing ? ((bus.PADDR == 3'd7) ? 32'h0 : bank[bus.PADDR]) : junk_data;
  assign bus.PSLVERR = completing ? (bus.PADDR == 3'd7) : junk_err;

  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE && !completing) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (completing && bus.PWRITE && bus.PADDR != 3'd7)
      bank[bus.PADDR] <= (bus.PADDR == 3'd1) ? {16'h0, bus.PWDATA[15:0]} : bus.PWDATA;
  end

  // Expected per-cycle outputs, produced one transaction at a time
  typedef struct packed {
    logic        rdy, psel, pen, pwrite;
    logic [2:0]  paddr;
    logic [31:0] pwdata;
    logic        rv;
    logic [31:0] rdata;
    logic        err, tmo;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        ce;
  logic        chk_en = 1'b0;
  logic [31:0] model_mem [0:7];
  logic        last_w;
  logic [2:0]  last_a;
  logic [31:0] last_d;

  task automatic push(input logic rdy, input logic psel, input logic pen, input logic rv,
                      input logic [31:0] rd, input logic er, input logic tm);
    exp_t e;
    e.rdy = rdy; e.psel = psel; e.pen = pen; e.rv = rv;
    e.rdata = rd; e.err = er; e.tmo = tm;
    e.pwrite = last_w; e.paddr = last_a; e.pwdata = last_d;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL trace_underrun: got no expectation at %0t", $time);
      end else begin
        ce = exp_q.pop_front();
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(ce.rdy));
        chk("PSEL",      32'(bus.PSEL),      32'(ce.psel));
        chk("PENABLE",   32'(bus.PENABLE),   32'(ce.pen));
        chk("PWRITE",    32'(bus.PWRITE),    32'(ce.pwrite));
        chk("PADDR",     32'(bus.PADDR),     32'(ce.paddr));
        chk("PWDATA",    bus.PWDATA,         ce.pwdata);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ce.rv));
        if (ce.rv) begin
          chk("rsp_rdata",   bus.rsp_rdata,        ce.rdata);
          chk("rsp_err",     32'(bus.rsp_err),     32'(ce.err));
          chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(ce.tmo));
        end
      end
    end
  end

  // Monitor: latency in edges from accept to first rsp_valid, ACCESS cycle count, response
  int          cyc = 0, acc_edge = 0, rv_edge = 0, acc_cycles = 0, last_lat = 0, last_acc = 0;
  logic        seen_rv = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0, last_tmo = 1'b0;

  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready && rst_n) begin
      acc_edge = cyc; acc_cycles = 0;
    end
    if (bus.PSEL && bus.PENABLE) acc_cycles++;
    if (bus.rsp_valid && !seen_rv) begin seen_rv = 1'b1; rv_edge = cyc; end
    if (bus.rsp_valid && bus.rsp_ready) begin
      last_rdata = bus.rsp_rdata; last_err = bus.rsp_err; last_tmo = bus.rsp_timeout;
      last_lat = rv_edge - acc_edge; last_acc = acc_cycles; seen_rv = 1'b0;
    end
    cyc++;
  end

  task automatic junk();
    junk_rdy  = 1'($urandom);
    junk_err  = 1'($urandom);
    junk_data = $urandom;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after the response.
  task automatic run_txn(input logic w, input logic [2:0] a, input logic [31:0] d,
                         input int gap, input int wn, input int rdly);
    int          n_acc, total;
    logic        tmo, eer;
    logic [31:0] erd;
    tmo   = (wn + 1 > TIMEOUT);
    n_acc = tmo ? TIMEOUT : wn + 1;
    if (tmo) begin
      erd = 32'h0; eer = 1'b1;
    end else begin
      eer = (a == 3'd7);
      erd = (w || eer) ? 32'h0 : model_mem[a];
      if (w && !eer) model_mem[a] = (a == 3'd1) ? (d & 32'h0000FFFF) : d;
    end
    for (int i = 0; i < gap; i++) push(1, 0, 0, 0, 0, 0, 0);
    last_w = w; last_a = a; last_d = d;
    push(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n_acc; i++) push(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i <= rdly; i++) push(0, 0, 0, 1, erd, eer, tmo);
    push(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    wait_n = wn;
    for (int i = 0; i < gap; i++) begin
      bus.cmd_valid = 1'b0; bus.rsp_ready = 1'($urandom); junk();
      @(negedge clk);
    end
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    bus.rsp_ready = 1'($urandom); junk();
    @(negedge clk);
    total = 1 + n_acc + rdly + 1;
    for (int j = 0; j < total; j++) begin
      // Keep offering junk commands while busy: none may be accepted.
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'($urandom);
      bus.cmd_addr = 3'($urandom); bus.cmd_wdata = $urandom;
      if (j > n_acc) bus.rsp_ready = ((j - n_acc - 1) == rdly);
      else bus.rsp_ready = 1'($urandom);
      junk();
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin bank[i] = 32'h0; model_mem[i] = 32'h0; end
    last_w = 1'b0; last_a = 3'd0; last_d = 32'h0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0; junk();
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_PSEL",      32'(bus.PSEL),      32'h0);
    chk("rst_PENABLE",   32'(bus.PENABLE),   32'h0);
    chk("rst_PADDR",     32'(bus.PADDR),     32'h0);
    chk("rst_PWDATA",    bus.PWDATA,         32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 3'd0, 32'hDEADBEEF, 0, 1, 0);
    chk("wr0_err", 32'(last_err), 32'h0);
    run_txn(1'b0, 3'd0, 32'h0, 0, 1, 0);
    chk("rd0_rdata", last_rdata, 32'hDEADBEEF);
    chk("rd0_lat",   32'(last_lat), 32'd4);
    run_txn(1'b1, 3'd1, 32'h00012345, 1, 1, 0);
    run_txn(1'b0, 3'd1, 32'h0, 0, 1, 0);
    chk("rd1_rdata", last_rdata, 32'h00002345);
    run_txn(1'b0, 3'd7, 32'h0, 0, 0, 0);
    chk("rd7_err",   32'(last_err), 32'h1);
    chk("rd7_tmo",   32'(last_tmo), 32'h0);
    chk("rd7_rdata", last_rdata, 32'h0);
    chk("rd7_lat",   32'(last_lat), 32'd3);
    run_txn(1'b0, 3'd0, 32'h0, 0, 100, 0);
    chk("tmo_tmo", 32'(last_tmo), 32'h1);
    chk("tmo_err", 32'(last_err), 32'h1);
    chk("tmo_acc", 32'(last_acc), 32'd4);
    run_txn(1'b0, 3'd0, 32'h0, 0, 3, 0);
    chk("late_tmo",   32'(last_tmo), 32'h0);
    chk("late_acc",   32'(last_acc), 32'd4);
    chk("late_rdata", last_rdata, 32'hDEADBEEF);
    run_txn(1'b1, 3'd2, 32'hA5A5_0F0F, 0, 0, 5);

    // Reset in the middle of a stalled write: nothing may complete or respond.
    chk_en = 1'b0;
    wait_n = 100;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd3; bus.cmd_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_PSEL",      32'(bus.PSEL),      32'h0);
    chk("arst_PENABLE",   32'(bus.PENABLE),   32'h0);
    chk("arst_PADDR",     32'(bus.PADDR),     32'h0);
    chk("arst_PWRITE",    32'(bus.PWRITE),    32'h0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_w = 1'b0; last_a = 3'd0; last_d = 32'h0;
    @(negedge clk);
    run_txn(1'b0, 3'd3, 32'h0, 0, 1, 0);
    chk("post_rst_rdata", last_rdata, 32'h0);
    chk("post_rst_err",   32'(last_err), 32'h0);

    for (int i = 0; i < 60; i++) begin
      int r, wn;
      r  = $urandom_range(0, 9);
      wn = (r < 7) ? (r % 4) : (r - 3);
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom_range(0, 2), wn, $urandom_range(0, 3));
    end

    bus.cmd_valid = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
